// File: rtl/alu_sequencer.sv
// Command front end for the single-core alu: accepts one command, drives the ALU
// operand/opcode registers, waits out the ALU result/zero latency and returns the result.
module alu_sequencer #(
    parameter int unsigned N     = 12,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [N-1:0]     cmd_a,
    input  logic [N-1:0]     cmd_b,
    output logic [N-1:0]     alu_in1,
    output logic [N-1:0]     alu_in2,
    output logic [2:0]       alu_op,
    input  logic [N-1:0]     alu_result,
    input  logic [15:0]      alu_z,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [N-1:0]     res_data,
    output logic             res_zero,
    output logic             res_err,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    localparam int unsigned OP_W = 3;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        EXEC = 3'd1,
        WAIT = 3'd2,
        CAPT = 3'd3,
        RESP = 3'd4
    } state_t;

    state_t           state, state_d;
    logic [N-1:0]     alu_in1_d, alu_in2_d, res_data_d;
    logic [OP_W-1:0]  alu_op_d;
    logic             res_valid_d, res_zero_d, res_err_d, busy_d;
    logic [CNT_W-1:0] op_count_d;
    logic             op_legal;
    logic             unused_z;

    // Only the LSB of the ALU zero bus carries the flag.
    assign unused_z  = ^alu_z[15:1];
    assign cmd_ready = (state == IDLE);
    assign op_legal  = (cmd_op >= OP_W'(1)) && (cmd_op <= OP_W'(4));

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            alu_in1   <= '0;
            alu_in2   <= '0;
            alu_op    <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_zero  <= 1'b0;
            res_err   <= 1'b0;
            busy      <= 1'b0;
            op_count  <= '0;
        end else begin
            state     <= state_d;
            alu_in1   <= alu_in1_d;
            alu_in2   <= alu_in2_d;
            alu_op    <= alu_op_d;
            res_valid <= res_valid_d;
            res_data  <= res_data_d;
            res_zero  <= res_zero_d;
            res_err   <= res_err_d;
            busy      <= busy_d;
            op_count  <= op_count_d;
        end
    end

    always_comb begin
        state_d     = state;
        alu_in1_d   = alu_in1;
        alu_in2_d   = alu_in2;
        alu_op_d    = alu_op;
        res_valid_d = res_valid;
        res_data_d  = res_data;
        res_zero_d  = res_zero;
        res_err_d   = res_err;
        op_count_d  = op_count;

        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    if (op_legal) begin
                        alu_in1_d = cmd_a;
                        alu_in2_d = cmd_b;
                        alu_op_d  = cmd_op;
                        state_d   = EXEC;
                    end else begin
                        // Illegal opcode is answered directly; the ALU is never touched.
                        res_err_d   = 1'b1;
                        res_data_d  = '0;
                        res_zero_d  = 1'b0;
                        res_valid_d = 1'b1;
                        state_d     = RESP;
                    end
                end
            end
            EXEC: begin
                // ALU samples the opcode at this edge; dropping to 0 makes it hold alu_out.
                alu_op_d = '0;
                state_d  = WAIT;
            end
            WAIT: begin
                state_d = CAPT;
            end
            CAPT: begin
                res_data_d  = alu_result;
                res_zero_d  = alu_z[0];
                res_err_d   = 1'b0;
                res_valid_d = 1'b1;
                if (op_count != '1) begin
                    op_count_d = op_count + CNT_W'(1);
                end
                state_d = RESP;
            end
            RESP: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

endmodule
